jtag_dm_mh: RTL



---
 rtl/jtag_dm_pkg.sv | 36 +++
 rtl/jtag_dm_hart_mux.sv | 34 +++
 rtl/jtag_dm_mh.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dm_pkg.sv
// Shared constants for the multi-hart JTAG debug module: DMI register map,
// op/response codes, abstract command error codes and FSM encoding.
package jtag_dm_pkg;

  localparam int DTM_REQ_BITS = 6 + 32 + 2;

  localparam logic [5:0] ADDR_DATA0       = 6'h04;
  localparam logic [5:0] ADDR_DMCONTROL   = 6'h10;
  localparam logic [5:0] ADDR_DMSTATUS    = 6'h11;
  localparam logic [5:0] ADDR_ABSTRACTCS  = 6'h16;
  localparam logic [5:0] ADDR_COMMAND     = 6'h17;
  localparam logic [5:0] ADDR_SBCS        = 6'h38;
  localparam logic [5:0] ADDR_SBADDRESS0  = 6'h39;
  localparam logic [5:0] ADDR_SBDATA0     = 6'h3C;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;
  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;

  localparam logic [2:0] CMDERR_NONE    = 3'd0;
  localparam logic [2:0] CMDERR_NOTSUP  = 3'd2;
  localparam logic [2:0] CMDERR_HALTED  = 3'd4;

  localparam logic [15:0] REGNO_GPR_LO = 16'h1000;
  localparam logic [15:0] REGNO_GPR_HI = 16'h101F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } dm_state_e;

endpackage

// File: rtl/jtag_dm_hart_mux.sv
// Combinational hartsel decode: one-hot request fan-out, selected-hart GPR
// read slice and the out-of-range (nonexistent hart) flag.
module jtag_dm_hart_mux #(
  parameter int HART_NUM     = 2,
  parameter int HARTSEL_BITS = 1
)(
  input  logic [HARTSEL_BITS-1:0] hartsel,
  input  logic                    halt_req,
  input  logic                    op_req,
  input  logic [HART_NUM*32-1:0]  rdata_all,
  output logic [HART_NUM-1:0]     halt_vec,
  output logic [HART_NUM-1:0]     op_vec,
  output logic [31:0]             rdata_sel,
  output logic                    nonexist
);

  logic [HART_NUM-1:0] hit;

  assign nonexist = 32'(hartsel) >= 32'(HART_NUM);

  for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
    assign hit[h]      = (32'(hartsel) == 32'(h));
    assign halt_vec[h] = halt_req & hit[h];
    assign op_vec[h]   = op_req & hit[h];
  end

  // An out-of-range hartsel hits nothing, so the slice falls back to zero.
  always_comb begin
    rdata_sel = '0;
    for (int h = 0; h < HART_NUM; h++)
      if (hit[h]) rdata_sel = rdata_all[h*32 +: 32];
  end

endmodule

// File: rtl/jtag_dm_mh.sv
// Multi-hart JTAG debug module: DMI register decode, abstract GPR commands and
// system-bus access. JTAG_DM_SBA_AUTOINC_EN enables sbaddress0 auto-increment.
module jtag_dm_mh
  import jtag_dm_pkg::*;
#(
  parameter int DMI_ADDR_BITS = 6,
  parameter int DMI_DATA_BITS = 32,
  parameter int DMI_OP_BITS   = 2,
  parameter int HART_NUM      = 2,
  parameter int HARTSEL_BITS  = 1
)(
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           dtm_req_valid_i,
  input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data_i,
  output logic                                           dm_ack_o,
  output logic                                           dm_resp_valid_o,
  output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data_o,
  input  logic                                           dtm_ack_i,
  output logic                                           dm_reg_we_o,
  output logic [4:0]                                     dm_reg_addr_o,
  output logic [31:0]                                    dm_reg_wdata_o,
  input  logic [HART_NUM*32-1:0]                         dm_reg_rdata_i,
  output logic                                           dm_mem_we_o,
  output logic [31:0]                                    dm_mem_addr_o,
  output logic [31:0]                                    dm_mem_wdata_o,
  input  logic [31:0]                                    dm_mem_rdata_i,
  output logic [HART_NUM-1:0]                            dm_op_req_o,
  output logic [HART_NUM-1:0]                            dm_halt_req_o,
  output logic [HART_NUM-1:0]                            dm_reset_req_o
);

  dm_state_e state_q, state_d;

  logic                     req_seen_q, ack_q;
  logic [DMI_ADDR_BITS-1:0] req_addr_q;
  logic [DMI_DATA_BITS-1:0] req_data_q;
  logic [DMI_OP_BITS-1:0]   req_op_q;
  logic [31:0]              resp_data_q;
  logic [DMI_OP_BITS-1:0]   resp_op_q;

  logic [31:0]             data0_q, sbaddr_q;
  logic                    haltreq_q, ndmreset_q, dmactive_q;
  logic [HARTSEL_BITS-1:0] hartsel_q;
  logic [2:0]              cmderr_q;
  logic                    sb_autoinc;

  logic        reg_we_q, mem_we_q, op_busy_q, wait_mem_q;
  logic [4:0]  reg_addr_q;
  logic [31:0] reg_wdata_q, mem_addr_q, mem_wdata_q;

  logic        capture, is_rd, is_wr, known, wr_en;
  logic        cmd_bad, cmd_go, sb_acc, exec_op, exec_wait, op_active;
  logic        nonexist, hart_halted;
  logic [31:0] rd_val, hart_rdata;

  assign capture = (state_q == ST_IDLE) && dtm_req_valid_i && !req_seen_q;
  assign is_rd   = (req_op_q == OP_READ);
  assign is_wr   = (req_op_q == OP_WRITE);
  assign wr_en   = is_wr && known && (dmactive_q || req_addr_q == ADDR_DMCONTROL);

  assign hart_halted = haltreq_q && !nonexist;
  assign cmd_bad = (req_data_q[31:24] != 8'd0) ||
                   (req_data_q[15:0] < REGNO_GPR_LO) || (req_data_q[15:0] > REGNO_GPR_HI);
  assign cmd_go  = is_wr && dmactive_q && (req_addr_q == ADDR_COMMAND) &&
                   (cmderr_q == CMDERR_NONE) && !cmd_bad && hart_halted && req_data_q[17];
  // Bus reads are allowed while inactive; only writes are gated by dmactive.
  assign sb_acc    = (req_addr_q == ADDR_SBDATA0) && (is_rd || (is_wr && dmactive_q));
  assign exec_op   = cmd_go || sb_acc;
  assign exec_wait = (cmd_go && !req_data_q[16]) || ((req_addr_q == ADDR_SBDATA0) && is_rd);
  assign op_active = ((state_q == ST_EXEC) && exec_op) || op_busy_q;

  always_comb begin
    known  = 1'b1;
    rd_val = '0;
    case (req_addr_q)
      ADDR_DATA0:      rd_val = data0_q;
      ADDR_DMCONTROL: begin
        rd_val[31]                 = haltreq_q;
        rd_val[16 +: HARTSEL_BITS] = hartsel_q;
        rd_val[1]                  = ndmreset_q;
        rd_val[0]                  = dmactive_q;
      end
      ADDR_DMSTATUS: begin
        rd_val[3:0] = 4'd2;
        rd_val[7]   = 1'b1;
        rd_val[8]   = hart_halted;
        rd_val[9]   = hart_halted;
        rd_val[14]  = nonexist;
      end
      ADDR_ABSTRACTCS: begin
        rd_val[10:8] = cmderr_q;
        rd_val[3:0]  = 4'd1;
      end
      ADDR_SBCS:       rd_val[16] = sb_autoinc;
      ADDR_SBADDRESS0: rd_val = sbaddr_q;
      ADDR_COMMAND, ADDR_SBDATA0: ;
      default:         known = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (capture) state_d = ST_EXEC;
      ST_EXEC: state_d = exec_wait ? ST_WAIT : ST_RESP;
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: if (dtm_ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

`ifdef JTAG_DM_SBA_AUTOINC_EN
  logic sb_autoinc_q;
  assign sb_autoinc = sb_autoinc_q;
`else
  assign sb_autoinc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      req_seen_q  <= 1'b0;
      ack_q       <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= '0;
      resp_data_q <= '0;
      resp_op_q   <= '0;
      data0_q     <= '0;
      sbaddr_q    <= '0;
      haltreq_q   <= 1'b0;
      ndmreset_q  <= 1'b0;
      dmactive_q  <= 1'b0;
      hartsel_q   <= '0;
      cmderr_q    <= CMDERR_NONE;
      reg_we_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      op_busy_q   <= 1'b0;
      wait_mem_q  <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef JTAG_DM_SBA_AUTOINC_EN
      sb_autoinc_q <= 1'b0;
`endif
    end else begin
      ack_q    <= 1'b0;
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      if (!dtm_req_valid_i) req_seen_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (capture) begin
          {req_addr_q, req_data_q, req_op_q} <= dtm_req_data_i;
          ack_q      <= 1'b1;
          req_seen_q <= 1'b1;
        end
        ST_EXEC: begin
          resp_op_q   <= ((is_rd || is_wr) && !known) ? RESP_FAIL : RESP_OK;
          resp_data_q <= is_rd ? rd_val : '0;
          op_busy_q   <= exec_op;
          wait_mem_q  <= (req_addr_q == ADDR_SBDATA0);
          if (wr_en) begin
            case (req_addr_q)
              ADDR_DATA0: data0_q <= req_data_q;
              ADDR_DMCONTROL: begin
                haltreq_q  <= req_data_q[31];
                hartsel_q  <= req_data_q[16 +: HARTSEL_BITS];
                ndmreset_q <= req_data_q[1];
                dmactive_q <= req_data_q[0];
              end
              ADDR_ABSTRACTCS: cmderr_q <= cmderr_q & ~req_data_q[10:8];
              ADDR_COMMAND: if (cmderr_q == CMDERR_NONE) begin
                if (cmd_bad)           cmderr_q <= CMDERR_NOTSUP;
                else if (!hart_halted) cmderr_q <= CMDERR_HALTED;
              end
`ifdef JTAG_DM_SBA_AUTOINC_EN
              ADDR_SBCS: sb_autoinc_q <= req_data_q[16];
`endif
              ADDR_SBADDRESS0: sbaddr_q <= req_data_q;
              default: ;
            endcase
          end
          if (cmd_go) begin
            reg_addr_q  <= req_data_q[4:0];
            reg_wdata_q <= data0_q;
            reg_we_q    <= req_data_q[16];
          end
          // The bus address is latched so auto-increment cannot move it under the strobe.
          if (sb_acc) begin
            mem_addr_q  <= sbaddr_q;
            mem_wdata_q <= req_data_q;
            mem_we_q    <= is_wr;
`ifdef JTAG_DM_SBA_AUTOINC_EN
            if (sb_autoinc_q) sbaddr_q <= sbaddr_q + 32'd4;
`endif
          end
        end
        ST_WAIT: begin
          if (wait_mem_q) resp_data_q <= dm_mem_rdata_i;
          else            data0_q     <= hart_rdata;
        end
        ST_RESP: if (dtm_ack_i) op_busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  jtag_dm_hart_mux #(
    .HART_NUM     (HART_NUM),
    .HARTSEL_BITS (HARTSEL_BITS)
  ) u_hart_mux (
    .hartsel   (hartsel_q),
    .halt_req  (dmactive_q && haltreq_q),
    .op_req    (dmactive_q && op_active),
    .rdata_all (dm_reg_rdata_i),
    .halt_vec  (dm_halt_req_o),
    .op_vec    (dm_op_req_o),
    .rdata_sel (hart_rdata),
    .nonexist  (nonexist)
  );

  assign dm_ack_o        = ack_q;
  assign dm_resp_valid_o = (state_q == ST_RESP);
  assign dm_resp_data_o  = {req_addr_q, resp_data_q, resp_op_q};
  assign dm_reg_we_o     = reg_we_q;
  assign dm_reg_addr_o   = reg_addr_q;
  assign dm_reg_wdata_o  = reg_wdata_q;
  assign dm_mem_we_o     = mem_we_q;
  assign dm_mem_addr_o   = mem_addr_q;
  assign dm_mem_wdata_o  = mem_wdata_q;
  assign dm_reset_req_o  = {HART_NUM{dmactive_q && ndmreset_q}};

endmodule
